// File: rtl/gpu_mem_pkg.sv
// Shared types and constants for the GPU memory responder.
// State codes are plain localparams so older tools that predate enums can use them.
package gpu_mem_pkg;

    localparam int GPU_MEM_ADR_W = 20;
    localparam int GPU_MEM_DAT_W = 32;

    typedef logic [2:0] mem_state_t;

    localparam mem_state_t IDLE = 3'd0;
    localparam mem_state_t LAT  = 3'd1;
    localparam mem_state_t BEAT = 3'd2;
    localparam mem_state_t GAP  = 3'd3;
    localparam mem_state_t DONE = 3'd4;

    typedef logic [2:0] burst_cnt_t;

    // A burst field of N means N+1 words, so 0..7 maps to 1..8.
    function automatic logic [3:0] burst_beats(input burst_cnt_t cnt);
        return {1'b0, cnt} + 4'd1;
    endfunction

endpackage

// File: rtl/gpu_mem_rsp_ram.sv
// Single-port word RAM with byte write enables and a registered read port.
// Only the read register is reset; the array keeps its contents across reset.
module gpu_mem_rsp_ram #(
    parameter int AW = 18
) (
    input  logic          clk,
    input  logic          i_rst,
    input  logic [AW-1:0] addr,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [31:0]   wdat,
    input  logic          rd_en,
    output logic [31:0]   rdat
);

    logic [31:0] mem [0:(1<<AW)-1];

    // Byte-lane write: lanes with a clear enable keep their old value.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[addr][8*b +: 8] <= wdat[8*b +: 8];
                end
            end
        end
    end

    // Registered read so the data lines up with the ack the responder raises next cycle.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            rdat <= '0;
        end else if (rd_en) begin
            rdat <= mem[addr];
        end
    end

endmodule

// File: rtl/gpu_mem_responder.sv
// VRAM-side responder for the GPU memory bus: accepts a burst request, waits
// LATENCY cycles, then returns one ack per word, optionally pausing one cycle
// after every WAIT_EVERY beats.
// Optional build macro GPU_MEM_RSP_STATS_EN adds beat counters and a sticky
// protocol error flag for a GPU that drops req before the final ack.
module gpu_mem_responder
    import gpu_mem_pkg::*;
#(
    parameter int MEM_AW     = 18,
    parameter int LATENCY    = 2,
    parameter int WAIT_EVERY = 0
) (
    input  logic                     clk,
    input  logic                     i_rst,
    input  logic                     req_i,
    input  logic                     wrt_i,
    input  logic [GPU_MEM_ADR_W-1:0] adr_i,
    input  burst_cnt_t               cnt_i,
    input  logic [3:0]               sel_i,
    input  logic [GPU_MEM_DAT_W-1:0] wdat_i,
    output logic [GPU_MEM_DAT_W-1:0] rdat_o,
    output logic                     ack_o,
    output logic                     busy_o
`ifdef GPU_MEM_RSP_STATS_EN
    ,
    output logic [31:0]              rd_beats_o,
    output logic [31:0]              wr_beats_o,
    output logic                     err_o
`endif
);

    localparam logic [7:0] LAT_INIT = 8'(LATENCY - 1);
    localparam logic [7:0] GAP_LEN  = 8'(WAIT_EVERY);

    mem_state_t        state;
    mem_state_t        state_nx;
    logic [MEM_AW-1:0] addr;
    logic [3:0]        beats_left;
    logic [7:0]        lat_cnt;
    logic [7:0]        gap_cnt;
    logic              wrt_q;
    logic              gap_hit;

    logic [MEM_AW-1:0] ram_addr;
    logic              ram_we;
    logic              ram_rd_en;

    // Request address bits above the RAM size alias onto lower words.
    generate
        if (MEM_AW < GPU_MEM_ADR_W) begin : g_alias
            logic unused_adr_hi;
            assign unused_adr_hi = ^adr_i[GPU_MEM_ADR_W-1:MEM_AW];
        end
    endgenerate

    assign gap_hit = (WAIT_EVERY != 0) && ((gap_cnt + 8'd1) == GAP_LEN);

    // Next-state decode for the burst sequencer.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_i) begin
                    state_nx = (LATENCY <= 1) ? BEAT : LAT;
                end
            end
            LAT: begin
                if (lat_cnt <= 8'd1) begin
                    state_nx = BEAT;
                end
            end
            BEAT: begin
                if (beats_left == 4'd1) begin
                    state_nx = DONE;
                end else if (gap_hit) begin
                    state_nx = GAP;
                end else begin
                    state_nx = BEAT;
                end
            end
            GAP:     state_nx = BEAT;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // RAM port steering: reads run one word ahead of the ack, writes land on the ack cycle.
    always_comb begin
        ram_addr  = addr;
        ram_we    = 1'b0;
        ram_rd_en = 1'b0;
        case (state)
            IDLE: begin
                ram_addr  = adr_i[MEM_AW-1:0];
                ram_rd_en = req_i & ~wrt_i;
            end
            LAT, GAP: begin
                ram_rd_en = ~wrt_q;
            end
            BEAT: begin
                if (wrt_q) begin
                    ram_we = 1'b1;
                end else begin
                    ram_addr  = addr + MEM_AW'(1);
                    ram_rd_en = 1'b1;
                end
            end
            default: begin
                ram_rd_en = 1'b0;
            end
        endcase
    end

    // Sequencer state, burst bookkeeping and registered handshake outputs.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state      <= IDLE;
            ack_o      <= 1'b0;
            busy_o     <= 1'b0;
            addr       <= '0;
            beats_left <= '0;
            lat_cnt    <= '0;
            gap_cnt    <= '0;
            wrt_q      <= 1'b0;
        end else begin
            state  <= state_nx;
            ack_o  <= (state_nx == BEAT);
            busy_o <= (state_nx != IDLE);
            case (state)
                IDLE: begin
                    if (req_i) begin
                        addr       <= adr_i[MEM_AW-1:0];
                        wrt_q      <= wrt_i;
                        beats_left <= burst_beats(cnt_i);
                        lat_cnt    <= LAT_INIT;
                        gap_cnt    <= '0;
                    end
                end
                LAT: begin
                    lat_cnt <= lat_cnt - 8'd1;
                end
                BEAT: begin
                    addr       <= addr + MEM_AW'(1);
                    beats_left <= beats_left - 4'd1;
                    gap_cnt    <= gap_hit ? 8'd0 : gap_cnt + 8'd1;
                end
                default: begin
                    lat_cnt <= lat_cnt;
                end
            endcase
        end
    end

    gpu_mem_rsp_ram #(
        .AW (MEM_AW)
    ) u_ram (
        .clk   (clk),
        .i_rst (i_rst),
        .addr  (ram_addr),
        .we    (ram_we),
        .be    (sel_i),
        .wdat  (wdat_i),
        .rd_en (ram_rd_en),
        .rdat  (rdat_o)
    );

`ifdef GPU_MEM_RSP_STATS_EN
    // Beat counters plus a sticky flag for req dropping while beats are still owed.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            rd_beats_o <= '0;
            wr_beats_o <= '0;
            err_o      <= 1'b0;
        end else begin
            if (state == BEAT) begin
                if (wrt_q) begin
                    wr_beats_o <= wr_beats_o + 32'd1;
                end else begin
                    rd_beats_o <= rd_beats_o + 32'd1;
                end
            end
            if (!req_i && busy_o &&
                ((state == LAT) || (state == GAP) ||
                 ((state == BEAT) && (beats_left != 4'd1)))) begin
                err_o <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gpu_mem_responder.sv
// Bench for gpu_mem_responder: a default-parameter instance plus a small
// instance with wait states, driven from a vector table and a few hand
// sequences, with read data checked against a word model through a queue.
module tb_gpu_mem_responder;

    typedef struct {
        bit          use_w;
        bit          wr;
        logic [19:0] adr;
        logic [2:0]  cnt;
        logic [31:0] dbase;
        logic [3:0]  sel3;
        int          exp_lat;
        logic [15:0] exp_pat;
    } vec_t;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        req_a;
    logic        req_w;
    logic        wrt_i;
    logic [19:0] adr_i;
    logic [2:0]  cnt_i;
    logic [3:0]  sel_i;
    logic [31:0] wdat_i;
    logic [31:0] rdat_a;
    logic [31:0] rdat_w;
    logic        ack_a;
    logic        ack_w;
    logic        busy_a;
    logic        busy_w;
`ifdef GPU_MEM_RSP_STATS_EN
    logic [31:0] rdb_a, wrb_a, rdb_w, wrb_w;
    logic        err_a, err_w;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int first_ack_cyc = 0;
    int last_ack_cyc = 0;

    logic [31:0] model_a [int];
    logic [31:0] model_w [int];
    logic [31:0] exp_q [$];
    vec_t        vecs [13];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    gpu_mem_responder #(
        .MEM_AW     (18),
        .LATENCY    (2),
        .WAIT_EVERY (0)
    ) dut (
        .clk    (clk),
        .i_rst  (i_rst),
        .req_i  (req_a),
        .wrt_i  (wrt_i),
        .adr_i  (adr_i),
        .cnt_i  (cnt_i),
        .sel_i  (sel_i),
        .wdat_i (wdat_i),
        .rdat_o (rdat_a),
        .ack_o  (ack_a),
        .busy_o (busy_a)
`ifdef GPU_MEM_RSP_STATS_EN
        ,
        .rd_beats_o (rdb_a),
        .wr_beats_o (wrb_a),
        .err_o      (err_a)
`endif
    );

    gpu_mem_responder #(
        .MEM_AW     (10),
        .LATENCY    (2),
        .WAIT_EVERY (2)
    ) dut_w (
        .clk    (clk),
        .i_rst  (i_rst),
        .req_i  (req_w),
        .wrt_i  (wrt_i),
        .adr_i  (adr_i),
        .cnt_i  (cnt_i),
        .sel_i  (sel_i),
        .wdat_i (wdat_i),
        .rdat_o (rdat_w),
        .ack_o  (ack_w),
        .busy_o (busy_w)
`ifdef GPU_MEM_RSP_STATS_EN
        ,
        .rd_beats_o (rdb_w),
        .wr_beats_o (wrb_w),
        .err_o      (err_w)
`endif
    );

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic vec_t mk(input bit use_w, input bit wr, input logic [19:0] adr,
                                input logic [2:0] cnt, input logic [31:0] dbase,
                                input logic [3:0] sel3, input int exp_lat, input logic [15:0] exp_pat);
        vec_t v;
        v.use_w   = use_w;
        v.wr      = wr;
        v.adr     = adr;
        v.cnt     = cnt;
        v.dbase   = dbase;
        v.sel3    = sel3;
        v.exp_lat = exp_lat;
        v.exp_pat = exp_pat;
        return v;
    endfunction

    function automatic logic [31:0] beat_data(input vec_t v, input int k);
        return v.dbase * 32'(k + 1);
    endfunction

    function automatic logic [3:0] beat_sel(input vec_t v, input int k);
        return (k == 2) ? v.sel3 : 4'hF;
    endfunction

    function automatic logic [31:0] model_rd(input bit w, input int a);
        if (w) return model_w.exists(a) ? model_w[a] : 32'h0;
        return model_a.exists(a) ? model_a[a] : 32'h0;
    endfunction

    task automatic model_wr(input bit w, input int a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] word;
        word = model_rd(w, a);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) word[8*b +: 8] = d[8*b +: 8];
        end
        if (w) model_w[a] = word;
        else   model_a[a] = word;
    endtask

    task automatic drop_req();
        req_a = 1'b0;
        req_w = 1'b0;
    endtask

    // Runs one burst as a GPU would: holds req, feeds write data on each ack, checks reads.
    task automatic apply_stimulus(input vec_t v, input bit hold_req, input int rst_after, input string name);
        int          beats;
        int          mask;
        int          base;
        int          got;
        int          budget;
        int          drive_cyc;
        int          a;
        bit          done_rst;
        logic        ack_s;
        logic [15:0] pat;
        logic [31:0] exp_d;
        beats = int'(v.cnt) + 1;
        mask  = v.use_w ? 32'h3FF : 32'h3FFFF;
        base  = int'(v.adr);
        if (!v.wr) begin
            for (int k = 0; k < beats; k++) exp_q.push_back(model_rd(v.use_w, (base + k) & mask));
        end
        wrt_i  = v.wr;
        adr_i  = v.adr;
        cnt_i  = v.cnt;
        wdat_i = beat_data(v, 0);
        sel_i  = beat_sel(v, 0);
        if (v.use_w) req_w = 1'b1;
        else         req_a = 1'b1;
        drive_cyc = cyc;
        got       = 0;
        budget    = 0;
        pat       = '0;
        done_rst  = 1'b0;
        while (got < beats && !done_rst && budget < 64) begin
            @(negedge clk);
            budget++;
            ack_s = v.use_w ? ack_w : ack_a;
            if (ack_s) begin
                if (got == 0) begin
                    first_ack_cyc = cyc;
                    if (v.exp_lat > 0) check_output({name, "_lat"}, 32'(cyc - drive_cyc), 32'(v.exp_lat));
                    check_output({name, "_busy"}, {31'd0, v.use_w ? busy_w : busy_a}, 32'd1);
                end
                if (cyc - first_ack_cyc < 16) pat[cyc - first_ack_cyc] = 1'b1;
                a = (base + got) & mask;
                if (v.wr) begin
                    wdat_i = beat_data(v, got);
                    sel_i  = beat_sel(v, got);
                    model_wr(v.use_w, a, wdat_i, sel_i);
                end else begin
                    exp_d = exp_q.pop_front();
                    check_output($sformatf("%s_rd%0d", name, got), v.use_w ? rdat_w : rdat_a, exp_d);
                end
                got++;
                last_ack_cyc = cyc;
                wrt_i = ~v.wr;
                adr_i = 20'hABCDE;
                cnt_i = 3'd0;
                if (got == beats && !hold_req) drop_req();
                if (rst_after > 0 && got == rst_after) begin
                    drop_req();
                    i_rst = 1'b1;
                    @(negedge clk);
                    check_output({name, "_rst_ack"}, {31'd0, ack_a}, 32'd0);
                    check_output({name, "_rst_busy"}, {31'd0, busy_a}, 32'd0);
                    i_rst = 1'b0;
                    done_rst = 1'b1;
                end
            end
        end
        if (!done_rst && got < beats) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout acks=%0d expected=%0d", name, got, beats);
            drop_req();
            exp_q.delete();
        end
        if (rst_after == 0) check_output({name, "_pat"}, {16'd0, pat}, {16'd0, v.exp_pat});
    endtask

    // Lets the responder pass DONE and settle, then confirms it is quiet.
    task automatic idle_gap(input bit use_w, input string name);
        repeat (3) @(negedge clk);
        check_output({name, "_idle_busy"}, {31'd0, use_w ? busy_w : busy_a}, 32'd0);
        check_output({name, "_idle_ack"}, {31'd0, use_w ? ack_w : ack_a}, 32'd0);
    endtask

    // Global time bound so a stuck handshake still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog cycles=%0d expected=finish", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence: reset, vector table, then back-to-back and reset-mid-burst cases.
    initial begin
        int prev_last;
        vecs[0]  = mk(0, 1, 20'h00100, 3'd0, 32'hDEADBEEF, 4'hF, 2, 16'h0001);
        vecs[1]  = mk(0, 0, 20'h00100, 3'd0, 32'h0,        4'hF, 2, 16'h0001);
        vecs[2]  = mk(0, 1, 20'h00202, 3'd0, 32'hFFFFFFFF, 4'hF, 2, 16'h0001);
        vecs[3]  = mk(0, 1, 20'h00200, 3'd7, 32'h11111111, 4'h3, 2, 16'h00FF);
        vecs[4]  = mk(0, 0, 20'h00200, 3'd7, 32'h0,        4'hF, 2, 16'h00FF);
        vecs[5]  = mk(0, 1, 20'h3FFFE, 3'd3, 32'h10000001, 4'hF, 2, 16'h000F);
        vecs[6]  = mk(0, 0, 20'h00000, 3'd1, 32'h0,        4'hF, 2, 16'h0003);
        vecs[7]  = mk(0, 0, 20'h3FFFE, 3'd1, 32'h0,        4'hF, 2, 16'h0003);
        vecs[8]  = mk(0, 1, 20'hC0005, 3'd0, 32'h5A5A5A5A, 4'hF, 2, 16'h0001);
        vecs[9]  = mk(0, 0, 20'h00005, 3'd0, 32'h0,        4'hF, 2, 16'h0001);
        vecs[10] = mk(0, 0, 20'h3FFFF, 3'd2, 32'h0,        4'hF, 2, 16'h0007);
        vecs[11] = mk(1, 1, 20'h00010, 3'd5, 32'h01010101, 4'hF, 2, 16'h00DB);
        vecs[12] = mk(1, 0, 20'h00010, 3'd5, 32'h0,        4'hF, 2, 16'h00DB);

        i_rst  = 1'b1;
        req_a  = 1'b1;
        req_w  = 1'b0;
        wrt_i  = 1'b1;
        adr_i  = 20'h00100;
        cnt_i  = 3'd0;
        sel_i  = 4'hF;
        wdat_i = 32'h12345678;
        repeat (3) begin
            @(negedge clk);
            check_output("reset_ack", {31'd0, ack_a}, 32'd0);
            check_output("reset_busy", {31'd0, busy_a}, 32'd0);
        end
        check_output("reset_rdat", rdat_a, 32'd0);
        req_a = 1'b0;
        i_rst = 1'b0;
        repeat (2) @(negedge clk);
        check_output("post_reset_busy", {31'd0, busy_a}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i], 1'b0, 0, $sformatf("vec%0d", i));
            idle_gap(vecs[i].use_w, $sformatf("vec%0d", i));
        end

        apply_stimulus(mk(0, 0, 20'h00200, 3'd1, 32'h0, 4'hF, 2, 16'h0003), 1'b1, 0, "b2b_first");
        prev_last = last_ack_cyc;
        apply_stimulus(mk(0, 0, 20'h00100, 3'd0, 32'h0, 4'hF, 0, 16'h0001), 1'b0, 0, "b2b_second");
        check_output("b2b_gap", {31'd0, (first_ack_cyc - prev_last) >= 2}, 32'd1);
        idle_gap(1'b0, "b2b");

        apply_stimulus(mk(0, 1, 20'h00300, 3'd7, 32'hA5A50001, 4'hF, 2, 16'h00FF), 1'b0, 0, "pre_fill");
        idle_gap(1'b0, "pre_fill");
        apply_stimulus(mk(0, 1, 20'h00300, 3'd7, 32'h0F0F0F0F, 4'hF, 2, 16'h0000), 1'b0, 2, "rst_mid");
        idle_gap(1'b0, "rst_mid");
        apply_stimulus(mk(0, 0, 20'h00300, 3'd7, 32'h0, 4'hF, 2, 16'h00FF), 1'b0, 0, "rst_readback");
        idle_gap(1'b0, "rst_readback");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gpu_mem_responder.md
Name: gpu_mem_responder

Overview:
- Synthesizable VRAM-side responder for the GPU memory bus: services the GPU's `adr/cnt/sel/wrt/req` initiator requests with ack-paced bursts.
- Backed by a 32-bit-word RAM with byte enables.
- Replaces the constant `ack=0`/`data=0` tie-off in GPU benches.
- Serves as the FPGA-side bridge shell in front of real VRAM.

Parameters:
- MEM_AW, 18, word-address width of backing RAM (2^18 words = 1 MB VRAM); upper request address bits ignored (aliased).
- LATENCY, 2, cycles from request acceptance to first ack (minimum 1).
- WAIT_EVERY, 0, insert one wait cycle after every N beats; 0 = no wait states.

Ports:
- clk  in  1  clock; everything on rising edge.
- i_rst  in  1  synchronous active-high reset.
- req_i  in  1  GPU request (GPU `req_o`); held until final ack.
- wrt_i  in  1  1 = write burst, 0 = read burst.
- adr_i  in  20  start word address.
- cnt_i  in  3  burst length minus one (1..8 words).
- sel_i  in  4  byte enables; write beats only, sampled each beat.
- wdat_i  in  32  write data (GPU `dat_o`) for the current beat.
- rdat_o  out  32  read data (GPU `dat_i`); valid only while ack_o=1 on a read.
- ack_o  out  1  one pulse per transferred beat.
- busy_o  out  1  high from acceptance through DONE.

Behaviour:
- Reset values: ack_o=0, rdat_o=0, busy_o=0, state=IDLE, beat counter=0.
- RAM contents are not cleared by reset.
- All outputs are registered.
- States: IDLE, LAT, BEAT, GAP, DONE.
- IDLE:
  - On req_i=1, latch adr_i[MEM_AW-1:0], cnt_i and wrt_i.
  - Set beat count = cnt_i+1 (4-bit).
  - Load latency counter with LATENCY-1. Go to LAT, or directly to BEAT if LATENCY=1.
  - busy_o=1 from the next cycle.
- LAT: decrement. At 0, go to BEAT. A read in LAT issues the RAM read of the start address so data is ready on the first ack.
- BEAT:
  - Assert ack_o for exactly one cycle.
  - Read: rdat_o = RAM[addr] in the same cycle as ack_o.
  - Write: on the ack cycle, RAM[addr] bytes where sel_i=1 take wdat_i; other bytes are unchanged.
  - After each beat: addr = addr+1 mod 2^MEM_AW (wraps 2^MEM_AW-1 -> 0); remaining beats -1.
  - Last beat -> DONE.
  - Else, if WAIT_EVERY != 0 and beats done % WAIT_EVERY == 0 -> GAP; else stay in BEAT (back-to-back acks).
- GAP: one cycle with ack_o=0 (read prefetch of next address), then BEAT.
- DONE:
  - One mandatory idle cycle; ack_o=0, busy_o=0 at the next edge. Return to IDLE.
  - A req_i still high in DONE is not accepted. It is accepted in IDLE the following cycle, so there is at least one non-ack cycle between bursts.
- req_i dropping mid-burst (protocol violation): the burst completes as latched. The GPU is required to hold req_i; the responder never aborts on it.
- Request fields (adr_i, cnt_i, wrt_i) are ignored after acceptance. sel_i and wdat_i are sampled on every write ack.
- i_rst mid-burst: immediate return to IDLE with ack_o=0. A partially written burst keeps the beats already acked.
- Read-after-write to the same address in consecutive bursts returns the new data; the DONE gap guarantees this.

Optional Feature:
- Macro GPU_MEM_RSP_STATS_EN.
- Defined:
  - Adds outputs rd_beats_o[31:0] and wr_beats_o[31:0], reset to 0, incremented on each read/write ack, wrapping at 2^32.
  - Adds err_o (sticky until i_rst), set when req_i falls while busy_o=1 before the final ack.
- Undefined: ports and logic are absent. Core behaviour is identical.

Decomposition:
- Package gpu_mem_pkg holds:
  - typedef mem_state_t (IDLE, LAT, BEAT, GAP, DONE)
  - typedef burst_cnt_t (logic [2:0])
  - constant GPU_MEM_ADR_W=20
  - constant GPU_MEM_DAT_W=32
  - function burst_beats(cnt) = cnt+1
- Sub-module gpu_mem_rsp_ram: single-port 2^MEM_AW x 32 RAM with 4-bit byte write enables and registered read.
- The FSM, counters and address increment stay in gpu_mem_responder.

Test Plan:
1. Reset then idle: i_rst=1 for 3 cycles with req_i=1 -> ack_o=0, busy_o=0, no acceptance until i_rst=0.
2. Write then read, one word: write adr=0x00100, cnt=0, sel=0xF, wdat=0xDEADBEEF; then read the same address.
   - Write: first ack exactly LATENCY (2) cycles after acceptance.
   - Read: rdat_o=0xDEADBEEF with its single ack.
3. Full burst with byte enables:
   - Write adr=0x00200, cnt=7, data 0x11111111*k, sel=0xF except beat 3 sel=0x3 over prior 0xFFFFFFFF.
   - 8 consecutive acks.
   - Read back: beat 3 = 0xFFFF3333.
4. Wrap-around: MEM_AW=18, write cnt=3 at adr=0x3FFFE -> words land at 0x3FFFE, 0x3FFFF, 0x00000, 0x00001.
   - Also: adr=0xC0005 aliases to 0x00005.
5. Wait states: WAIT_EVERY=2, read cnt=5 -> ack pattern 1,1,0,1,1,0,1,1 after latency; data order preserved.
6. Back-to-back and reset mid-burst:
   - req_i held across two bursts -> at least one ack_o=0 cycle between the last and first acks.
   - i_rst asserted after beat 2 of an 8-beat write -> ack stops next cycle; words 0-1 written, 2-7 unchanged.
